// File: rtl/acc_rr_sched.sv
// acc_rr_sched: round-robin scheduler sharing one valid/ready access port among n_in requesters with bounded bursts
module acc_rr_sched #(
  parameter int n_in       = 8,
  parameter int data_width = 132,
  parameter int max_burst  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [n_in-1:0]              req,
  input  logic [n_in*data_width-1:0]   d_IN,
  output logic [n_in-1:0]              grant,
  output logic [data_width-1:0]        d_OUT,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         active,
  output logic                         busy,
  output logic [31:0]                  xfer_count
);
  localparam int pw = $clog2(n_in);
  typedef enum logic {IDLE, SERV} state_t;
  state_t          r_state, w_state_nx;
  logic [pw-1:0]   r_owner, r_ptr, w_owner_nx, w_ptr_nx, w_pick;
  logic [3:0]      r_beat, w_beat_nx;
  logic [31:0]     r_xfer;
  logic            w_xfer, w_last, w_rel;
  function automatic logic [pw-1:0] wrap(input int v);
    return pw'(v >= n_in ? v - n_in : v);
  endfunction
  assign active     = |req;
  assign busy       = r_state == SERV;
  assign grant      = {{(n_in-1){1'b0}}, busy} << r_owner;
  assign d_OUT      = busy ? d_IN[r_owner*data_width +: data_width] : '0;
  assign out_valid  = busy & req[r_owner];
  assign w_xfer     = out_valid & out_ready;
  assign w_last     = r_beat == 4'(max_burst - 1);
  assign w_rel      = busy & (~req[r_owner] | (w_xfer & w_last));
  assign xfer_count = r_xfer;
  // descending scan so the lowest offset from ptr wins
  always_comb begin
    w_pick = r_ptr;
    for (int k = n_in - 1; k >= 0; k--)
      if (req[wrap(int'(r_ptr) + k)]) w_pick = wrap(int'(r_ptr) + k);
  end
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_beat_nx  = r_beat;
    if (!busy) begin
      if (active) begin
        w_state_nx = SERV;
        w_owner_nx = w_pick;
        w_beat_nx  = '0;
      end
    end else if (w_rel) begin
      w_state_nx = IDLE;
      w_ptr_nx   = wrap(int'(r_owner) + 1);
      w_beat_nx  = '0;
    end else begin
      w_beat_nx  = r_beat + 4'(w_xfer);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
      r_xfer  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_beat  <= w_beat_nx;
      r_xfer  <= r_xfer + 32'(w_xfer);
    end
  end
endmodule

// File: doc/acc_rr_sched.md
# acc_rr_sched

Round-robin access scheduler that shares one downstream access port (memory/interconnect) among `n_in` requesters. It replaces the stateless conflict-flop tree for paths that need fair rotation, bounded bursts and a valid/ready handshake toward the shared resource. The block sits between the requester-side `req`/`d_IN` bundle and the single shared `d_OUT` port. It owns grant sequencing and transfer counting.

## Interface
- `n_in`, 8, number of requesters (2..16).
- `data_width`, 132, width of each requester's access word.
- `max_burst`, 4, maximum transfers per grant (1..15).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `n_in`  request per requester; bit i belongs to requester i.
- `d_IN`  in  `n_in*data_width`  flattened access words; requester i occupies bits `[i*data_width +: data_width]`.
- `grant`  out  `n_in`  one-hot grant; all-zero when no owner.
- `d_OUT`  out  `data_width`  access word of current owner; zero when no owner.
- `out_valid`  out  1  `d_OUT` valid toward shared port.
- `out_ready`  in  1  shared port accepts `d_OUT` this cycle.
- `active`  out  1  OR of all `req` bits (combinational).
- `busy`  out  1  FSM in SERV.
- `xfer_count`  out  32  total completed transfers; wraps.

## Operation
- State: FSM {IDLE, SERV}, `owner` (clog2(n_in) bits), `ptr` (clog2(n_in) bits), `beat` (4 bits), `xfer_count`.
- IDLE
  - If any `req` bit is set, the FSM picks the first set index scanning `ptr`, `ptr+1`, ... modulo `n_in`, with `ptr` inclusive.
  - It loads `owner` with that index, clears `beat`, and moves to SERV.
  - With no request it stays in IDLE.
- SERV
  - `grant` = one-hot(`owner`); `d_OUT` = `d_IN[owner]`.
  - `out_valid` = `req[owner]`.
  - Transfer is `out_valid & out_ready`. Each transfer increments `beat` and `xfer_count`.
- Release from SERV to IDLE occurs at an edge where either of these holds:
  - `req[owner]` = 0, with no transfer that cycle; or
  - a transfer occurs with `beat` = `max_burst`-1.
- On release: `ptr` <= (`owner`+1) mod `n_in`, and `beat` <= 0.
- Grant is held while `out_ready` = 0; the scheduler never preempts a stalled owner.
- `xfer_count` wraps from 0xFFFFFFFF to 0.
- `grant`, `d_OUT`, `out_valid` and `busy` are decoded from registered state plus `req[owner]`. There is no combinational path from `out_ready` to any output.

## Timing
- Reset values:
  - state IDLE; `ptr`, `owner`, `beat` all 0.
  - `grant` 0, `d_OUT` 0, `out_valid` 0, `busy` 0, `xfer_count` 0.
  - `active` follows `req` even during reset.
- Grant latency: `req[i]` high at edge N with the FSM in IDLE gives `grant[i]` = 1 in cycle N+1.
- Re-arbitration: every release costs exactly one IDLE bubble cycle. The next grant appears 2 cycles after the releasing edge.
- Burst: with `out_ready` held at 1, the owner gets `max_burst` consecutive transfer cycles, then 1 bubble.
- Simultaneous requests: lowest index at or after `ptr` wins. The others wait at most (`n_in`-1) grants.
- Owner drops `req` while `out_valid` is high and `out_ready` is 0:
  - `out_valid` falls the same cycle;
  - no transfer occurs;
  - release happens at the next edge.
- `rst` asserted mid-burst: outputs take reset values from the cycle after that edge. The in-flight burst is abandoned and not counted.
- `n_in` not a power of 2: `ptr` wraps from `n_in`-1 to 0. Indices ≥ `n_in` are never granted.

## Test plan
- Reset, then `req`=0 for 10 cycles -> `grant`=0, `out_valid`=0, `busy`=0, `xfer_count`=0 throughout.
- `n_in`=4, `max_burst`=4, `req`=4'b1111, `out_ready`=1 held 20 cycles -> grant sequence 0,0,0,0,bubble,1×4,bubble,2×4,bubble,3×4,bubble, then 0 again; `xfer_count`=16.
- `req`=4'b0100 only, `out_ready` low 3 cycles then high -> `grant`=4'b0100 from cycle 2; `out_valid` high, `d_OUT`=`d_IN[2]` stable during stall; first transfer on cycle 5; `beat` does not advance while stalled.
- Requester 1 granted, drops `req[1]` after 2 transfers -> release at that edge; `ptr`=2; with `req`=4'b1001 pending, next grant is 3 (not 0).
- `rst` pulsed for 1 cycle while owner 2 is on beat 2 of 4 -> `grant`=0 and `xfer_count`=0 next cycle; after `rst` falls with `req`=4'b0100, grant returns to 2 after 1 cycle starting at `beat` 0.
- Preload `xfer_count` near wrap via 2^32-2 forced transfers (or a backdoor force), then 3 transfers -> counter reads 0xFFFFFFFF, then 0, then 1.
